// File: rtl/apb_pkg.sv
// Shared APB definitions used by the requester and the 16-entry register slave.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 8;
  localparam int APB_DEPTH  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_m_state_e;

endpackage

// File: rtl/apb_m_chk.sv
// Protocol invariants for the APB requester, observed on its registered outputs.
module apb_m_chk (
  input logic pclk,
  input logic preset,
  input logic cmd_ready,
  input logic psel,
  input logic penable,
  input logic rsp_valid,
  input logic rsp_err,
  input logic rsp_timeout
);

  a_enable_needs_select: assert property (@(posedge pclk) disable iff (preset)
    penable |-> psel)
    else $error("apb_m_chk: penable without psel");

  a_idle_is_quiet: assert property (@(posedge pclk) disable iff (preset)
    cmd_ready |-> (!psel && !penable && !rsp_valid))
    else $error("apb_m_chk: bus or response active while accepting commands");

  a_rsp_excludes_bus: assert property (@(posedge pclk) disable iff (preset)
    rsp_valid |-> !psel)
    else $error("apb_m_chk: response presented while bus selected");

  a_timeout_is_error: assert property (@(posedge pclk) disable iff (preset)
    rsp_timeout |-> rsp_err)
    else $error("apb_m_chk: timeout without error flag");

endmodule

// File: rtl/apb_m.sv
// APB3 requester: one local command in, one single APB transfer, one response out.
module apb_m
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_m_state_e      state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [ADDR_W-1:0] paddr_r, paddr_s;
  logic              psel_r, psel_s;
  logic              penable_r, penable_s;
  logic              pwrite_r, pwrite_s;
  logic [DATA_W-1:0] pwdata_r, pwdata_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              rsp_err_r, rsp_err_s;
  logic              rsp_timeout_r, rsp_timeout_s;

  assign cmd_ready   = (state_r == IDLE);
  assign paddr       = paddr_r;
  assign psel        = psel_r;
  assign penable     = penable_r;
  assign pwrite      = pwrite_r;
  assign pwdata      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

  // Next-state and next-register decode; every register holds unless a state says otherwise.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    paddr_s       = paddr_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    pwrite_s      = pwrite_r;
    pwdata_s      = pwdata_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    rsp_timeout_s = rsp_timeout_r;

    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          paddr_s  = cmd_addr;
          pwrite_s = cmd_write;
          pwdata_s = cmd_write ? cmd_wdata : {DATA_W{1'b0}};
          psel_s   = 1'b1;
          state_s  = SETUP;
        end else begin
          state_s = IDLE;
        end
      end

      SETUP: begin
        penable_s = 1'b1;
        cnt_s     = {CNT_W{1'b0}};
        state_s   = ACCESS;
      end

      ACCESS: begin
        // A completing pready wins over an expiring timeout in the same cycle.
        if (pready) begin
          rsp_rdata_s   = pwrite_r ? {DATA_W{1'b0}} : prdata;
          rsp_err_s     = pslverr;
          rsp_timeout_s = 1'b0;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          state_s       = RESP;
        end else if (cnt_r == CNT_LAST) begin
          rsp_rdata_s   = {DATA_W{1'b0}};
          rsp_err_s     = 1'b1;
          rsp_timeout_s = 1'b1;
          psel_s        = 1'b0;
          penable_s     = 1'b0;
          rsp_valid_s   = 1'b1;
          state_s       = RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = RESP;
        end
      end

      default: begin
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      paddr_r       <= {ADDR_W{1'b0}};
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      pwdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DATA_W{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      paddr_r       <= paddr_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      pwrite_r      <= pwrite_s;
      pwdata_r      <= pwdata_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  apb_m_chk u_chk (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_ready   (cmd_ready),
    .psel        (psel),
    .penable     (penable),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout)
  );

endmodule
